// File: rtl/erc2_uart_loader_if.sv
// Memory-write / status bundle between the UART boot loader and the erc2-v core.
// The loader is the master: it drives the write port and status levels and listens to uart_rx.
interface erc2_uart_loader_if #(
    parameter int ADDR_W = 3
);
    logic              uart_rx;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_error;
    logic              busy;

    modport master (
        input  uart_rx,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output cpu_reset,
        output load_done,
        output load_error,
        output busy
    );

    modport slave (
        output uart_rx,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  cpu_reset,
        input  load_done,
        input  load_error,
        input  busy
    );
endinterface

// File: rtl/erc2_uart_loader.sv
// UART boot loader: receives an A5-framed, XOR-checksummed image, writes it word by word
// into core memory and keeps the core in reset until a complete valid image has arrived.
module erc2_uart_loader #(
    parameter int CLKS_PER_BIT = 217,
    parameter int MEM_WORDS    = 8,
    parameter int ADDR_W       = 3,
    parameter int TIMEOUT_CLKS = 2500000
) (
    input  logic               clk_25mhz,
    input  logic               reset,
    erc2_uart_loader_if.master bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int TMO_W = $clog2(TIMEOUT_CLKS);
    localparam int IDX_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TMO_W-1:0] TMO_M1    = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;
    localparam logic [7:0]       MAX_N     = 8'(MEM_WORDS);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        WAIT_SYNC,
        GET_COUNT,
        GET_DATA,
        GET_CSUM,
        DONE
    } ld_state_t;

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    logic [1:0]       sync_q;
    logic             rx_prev_q;
    logic             rx_s;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             rx_ferr_q, rx_ferr_d;

    assign rx_s = sync_q[1];

    // Synchronizer resets to the idle level so leaving reset never looks like a start edge.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            sync_q       <= 2'b11;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            byte_valid_q <= 1'b0;
            rx_ferr_q    <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], bus.uart_rx};
            rx_prev_q    <= rx_s;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            byte_valid_q <= byte_valid_d;
            rx_ferr_q    <= rx_ferr_d;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        byte_valid_d = 1'b0;
        rx_ferr_d    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == FULL_M1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == FULL_M1) begin
                    rx_cnt_d     = '0;
                    rx_state_d   = RX_IDLE;
                    byte_valid_d = rx_s;
                    rx_ferr_d    = !rx_s;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    ld_state_t         state_q, state_d;
    logic [IDX_W-1:0]  n_q, n_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  idx_inc;
    logic [7:0]        csum_q, csum_d;
    logic [23:0]       word_q, word_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              load_done_q, load_done_d;
    logic              load_error_q, load_error_d;
    logic              in_frame;
    logic              tmo_expired;
    logic              bad_byte;

    assign in_frame    = state_q inside {GET_COUNT, GET_DATA, GET_CSUM};
    assign tmo_expired = !byte_valid_q && (tmo_q == TMO_M1);
    assign idx_inc     = idx_q + IDX_W'(1);

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state_q      <= WAIT_SYNC;
            n_q          <= '0;
            idx_q        <= '0;
            csum_q       <= '0;
            word_q       <= '0;
            byte_cnt_q   <= '0;
            tmo_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            csum_q       <= csum_d;
            word_q       <= word_d;
            byte_cnt_q   <= byte_cnt_d;
            tmo_q        <= tmo_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        idx_d        = idx_q;
        csum_d       = csum_q;
        word_d       = word_q;
        byte_cnt_d   = byte_cnt_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_reset_d  = cpu_reset_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;
        bad_byte     = 1'b0;
        tmo_d        = (!in_frame || byte_valid_q) ? '0 : tmo_q + TMO_W'(1);

        case (state_q)
            WAIT_SYNC, DONE: begin
                if (byte_valid_q && rx_shift_q == SYNC_BYTE) begin
                    cpu_reset_d  = 1'b1;
                    load_done_d  = 1'b0;
                    load_error_d = 1'b0;
                    idx_d        = '0;
                    csum_d       = '0;
                    byte_cnt_d   = '0;
                    state_d      = GET_COUNT;
                end
            end
            GET_COUNT: begin
                if (byte_valid_q) begin
                    if (rx_shift_q != 8'd0 && rx_shift_q <= MAX_N) begin
                        n_d     = rx_shift_q[IDX_W-1:0];
                        state_d = GET_DATA;
                    end else begin
                        bad_byte = 1'b1;
                    end
                end
            end
            GET_DATA: begin
                if (byte_valid_q) begin
                    // Little-endian: earlier bytes drift toward bit 0 as later ones arrive.
                    csum_d     = csum_q ^ rx_shift_q;
                    word_d     = {rx_shift_q, word_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = idx_q[ADDR_W-1:0];
                        mem_wdata_d = {rx_shift_q, word_q};
                        idx_d       = idx_inc;
                        if (idx_inc == n_q) begin
                            state_d = GET_CSUM;
                        end
                    end
                end
            end
            GET_CSUM: begin
                if (byte_valid_q) begin
                    if (rx_shift_q == csum_q) begin
                        load_done_d = 1'b1;
                        cpu_reset_d = 1'b0;
                        state_d     = DONE;
                    end else begin
                        bad_byte = 1'b1;
                    end
                end
            end
            default: state_d = WAIT_SYNC;
        endcase

        // Words already written are left in memory; only the status reflects the failure.
        if (in_frame && (bad_byte || rx_ferr_q || tmo_expired)) begin
            load_error_d = 1'b1;
            cpu_reset_d  = 1'b1;
            state_d      = WAIT_SYNC;
        end
    end

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.load_done  = load_done_q;
    assign bus.load_error = load_error_q;
    assign bus.busy       = in_frame;

endmodule

// File: tb/tb_erc2_uart_loader.sv
// Self-checking bench for erc2_uart_loader: byte-level frame model with an expected-write
// queue, directed frames from the test plan and randomized frames.
module tb_erc2_uart_loader;
    localparam int CPB       = 16;
    localparam int MEM_WORDS = 8;
    localparam int ADDR_W    = 3;
    localparam int TMO       = 600;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    erc2_uart_loader_if #(.ADDR_W(ADDR_W)) bus ();

    erc2_uart_loader #(
        .CLKS_PER_BIT(CPB),
        .MEM_WORDS   (MEM_WORDS),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk_25mhz(clk),
        .reset    (rst),
        .bus      (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Frame model: 0 idle (wait-sync or done), 1 count, 2 data, 3 checksum.
    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          m_state, m_n, m_idx, m_nb;
    logic [7:0]  m_csum;
    logic [31:0] m_word;
    bit          m_done, m_err;

    logic [7:0] valid_frame [7] = '{8'hA5, 8'h01, 8'h13, 8'h01, 8'hC0, 8'h0C, 8'hDE};

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_state = 0;
        m_done  = 0;
        m_err   = 0;
        exp_q.delete();
    endfunction

    function automatic void model_err();
        m_err   = 1;
        m_state = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        case (m_state)
            0: if (b == 8'hA5) begin
                m_done = 0; m_err = 0; m_idx = 0; m_nb = 0;
                m_csum = 0; m_word = 0; m_state = 1;
            end
            1: if (b >= 1 && b <= MEM_WORDS) begin
                m_n = int'(b);
                m_state = 2;
            end else model_err();
            2: begin
                m_word = m_word | (32'(b) << (8 * (m_nb % 4)));
                m_csum = m_csum ^ b;
                m_nb++;
                if (m_nb % 4 == 0) begin
                    exp_q.push_back('{m_idx, m_word});
                    m_word = 0;
                    m_idx++;
                    if (m_idx == m_n) m_state = 3;
                end
            end
            default: if (b == m_csum) begin
                m_done  = 1;
                m_state = 0;
            end else model_err();
        endcase
    endfunction

    // Every write strobe must match the next word the model expects.
    always @(negedge clk) begin
        if (!rst && bus.mem_we) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: got write addr %0d data %0h, expected no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("strobe_addr", 32'(bus.mem_addr), 32'(w.addr));
                chk("strobe_data", bus.mem_wdata, w.data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_levels(input string tag);
        chk({tag, "_load_done"}, 32'(bus.load_done), 32'(m_done));
        chk({tag, "_load_error"}, 32'(bus.load_error), 32'(m_err));
        chk({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'(!m_done));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(m_state != 0));
        chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'd1);
        chk({tag, "_load_done"}, 32'(bus.load_done), 32'd0);
        chk({tag, "_load_error"}, 32'(bus.load_error), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic tx_raw(input logic [7:0] b, input logic stop_bit);
        bus.uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = b[i];
            tick(CPB);
        end
        bus.uart_rx = stop_bit;
        tick(CPB);
        if (!stop_bit) begin
            bus.uart_rx = 1'b1;
            tick(CPB);
        end
    endtask

    task automatic send(input logic [7:0] b);
        model_byte(b);
        tx_raw(b, 1'b1);
        check_levels($sformatf("byte_%02h", b));
        $display("byte %02h sent: done=%0d err=%0d cpu_reset=%0d busy=%0d",
                 b, bus.load_done, bus.load_error, bus.cpu_reset, bus.busy);
        tick($urandom_range(0, 30));
    endtask

    task automatic send_ferr(input logic [7:0] b);
        if (m_state != 0) model_err();
        tx_raw(b, 1'b0);
        check_levels("framing");
        $display("byte %02h sent with bad stop bit: err=%0d", b, bus.load_error);
        tick($urandom_range(0, 30));
    endtask

    task automatic glitch();
        bus.uart_rx = 1'b0;
        tick(5);
        bus.uart_rx = 1'b1;
        tick(2 * CPB);
        check_levels("glitch");
        $display("glitch applied: done=%0d err=%0d", bus.load_done, bus.load_error);
    endtask

    task automatic rand_frame();
        int         n, kind, ferr_pos;
        logic [7:0] b, cs;
        n        = $urandom_range(1, MEM_WORDS);
        kind     = $urandom_range(0, 5);
        ferr_pos = $urandom_range(0, 4 * n - 1);
        cs       = 8'h00;
        send(8'hA5);
        if (kind == 0) begin
            b = ($urandom_range(0, 1) == 1) ? 8'd0 : 8'($urandom_range(MEM_WORDS + 1, 255));
            send(b);
            return;
        end
        send(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            if (kind == 1 && i == ferr_pos) begin
                send_ferr(b);
                return;
            end
            cs = cs ^ b;
            send(b);
        end
        if (kind == 2) send(cs ^ 8'($urandom_range(1, 255)));
        else           send(cs);
        if (kind == 3) glitch();
        if (kind == 4) send_ferr(8'hA5);
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        bus.uart_rx = 1'b1;
        model_reset();
        tick(4);
        check_reset_vals("reset");
        rst = 1'b0;
        tick(4);

        // Single-word valid load.
        for (int i = 0; i < 7; i++) send(valid_frame[i]);
        chk("valid_addr_pin", 32'(bus.mem_addr), 32'd0);
        chk("valid_data_pin", bus.mem_wdata, 32'h0CC00113);
        chk("valid_done_pin", 32'(bus.load_done), 32'd1);
        chk("valid_cpu_reset_pin", 32'(bus.cpu_reset), 32'd0);

        // Framing error and glitch outside a frame leave a finished load untouched.
        send_ferr(8'hA5);
        glitch();
        chk("idle_noise_done_pin", 32'(bus.load_done), 32'd1);

        // Restart then full image with no address wrap.
        send(8'hA5);
        chk("restart_cpu_reset_pin", 32'(bus.cpu_reset), 32'd1);
        send(8'd8);
        for (int w = 0; w < 8; w++) begin
            send(8'(w));
            send(8'h00);
            send(8'h00);
            send(8'h00);
        end
        send(8'h00);
        chk("full_addr_pin", 32'(bus.mem_addr), 32'd7);
        chk("full_data_pin", bus.mem_wdata, 32'd7);
        chk("full_done_pin", 32'(bus.load_done), 32'd1);

        // Bad checksum.
        for (int i = 0; i < 6; i++) send(valid_frame[i]);
        send(8'h00);
        chk("badcsum_err_pin", 32'(bus.load_error), 32'd1);
        chk("badcsum_cpu_reset_pin", 32'(bus.cpu_reset), 32'd1);

        // Bad counts.
        send(8'hA5);
        send(8'h00);
        chk("count0_err_pin", 32'(bus.load_error), 32'd1);
        send(8'hA5);
        chk("count_sync_clears_err_pin", 32'(bus.load_error), 32'd0);
        send(8'h09);
        chk("count9_err_pin", 32'(bus.load_error), 32'd1);

        // Timeout after two data bytes: quiet just short of the limit, error just past it.
        send(8'hA5);
        send(8'h02);
        send(8'h11);
        send(8'h22);
        tick(TMO - 60);
        check_levels("pre_timeout");
        chk("pre_timeout_err_pin", 32'(bus.load_error), 32'd0);
        model_err();
        tick(120);
        check_levels("post_timeout");
        chk("post_timeout_err_pin", 32'(bus.load_error), 32'd1);

        // Framing error mid-frame.
        send(8'hA5);
        send(8'h01);
        send(8'h33);
        send_ferr(8'h44);
        chk("ferr_err_pin", 32'(bus.load_error), 32'd1);

        // Reset in the middle of GET_DATA.
        send(8'hA5);
        send(8'h02);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        send(8'h55);
        rst = 1'b1;
        tick(1);
        check_reset_vals("midframe_reset");
        model_reset();
        rst = 1'b0;
        tick(2);
        send(8'h66);
        send(8'h77);
        send(8'h88);
        send(8'h5A);

        // Randomized frames.
        for (int r = 0; r < 8; r++) rand_frame();
        tick(10);
        check_levels("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/erc2_uart_loader.md
# erc2_uart_loader

Boot loader placed upstream of the erc2-v core: receives a program over UART, writes it word by word into the core's 32-bit instruction/data memory, and holds the core in reset until a complete, checksum-valid image has been loaded. After a successful load it releases `cpu_reset`. A new sync byte restarts the load at any time.

## Interface
- `CLKS_PER_BIT`, 217, clk_25mhz cycles per UART bit (115200 baud).
- `MEM_WORDS`, 8, memory depth in 32-bit words.
- `ADDR_W`, 3, word-address width (clog2 of MEM_WORDS).
- `TIMEOUT_CLKS`, 2500000, idle cycles allowed between bytes inside a frame (100 ms).
- Clock and reset: clock `clk_25mhz`; reset `reset`, synchronous, active-high.
- `clk_25mhz`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `uart_rx`  in  1  asynchronous serial input, idle high, 8N1, LSB first.
- `mem_we`  out  1  one-cycle write strobe to memory.
- `mem_addr`  out  ADDR_W  word address for the write.
- `mem_wdata`  out  32  word to write.
- `cpu_reset`  out  1  holds the core in reset while high.
- `load_done`  out  1  level, high after a valid load.
- `load_error`  out  1  level, sticky until next accepted sync byte or reset.
- `busy`  out  1  high while a frame is in progress (GET_COUNT..GET_CSUM).

## Operation
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_reset`=1, `load_done`=0, `load_error`=0, `busy`=0, FSM=WAIT_SYNC, RX=IDLE.
- The frame format is: 0xA5, N (1..MEM_WORDS), then N words of 4 bytes each (little-endian), then CSUM. CSUM is the XOR of all 4N data bytes.
- UART RX:
  - `uart_rx` passes through a 2-flop synchronizer.
  - A high-to-low edge in IDLE starts a bit counter.
  - At CLKS_PER_BIT/2 the line is re-sampled. If it is high, this was a glitch and RX returns to IDLE.
  - 8 data bits are then sampled every CLKS_PER_BIT, followed by the stop bit.
  - If the stop bit is 0, this is a framing error: the byte is discarded. Inside a frame the error is handled the same as a frame error. Outside a frame it is ignored.
  - Otherwise a one-cycle internal `byte_valid` fires.
- Loader FSM:
  - WAIT_SYNC: a 0xA5 byte causes `cpu_reset`=1, `load_done`=0, `load_error`=0, word index=0, checksum=0, and a move to GET_COUNT. Any other byte is ignored.
  - GET_COUNT: if N is between 1 and MEM_WORDS, latch N and go to GET_DATA. Otherwise it is a frame error.
  - GET_DATA: shift in bytes, filling bits [7:0] first. On the 4th byte, pulse `mem_we` with `mem_addr`=index and `mem_wdata`=the assembled word, then increment index. Every data byte is XORed into the checksum. When index reaches N, go to GET_CSUM.
  - GET_CSUM: a match sets `load_done`=1 and `cpu_reset`=0, then go to DONE. A mismatch is a frame error.
  - DONE: behaves like WAIT_SYNC, so a 0xA5 byte restarts the load and reasserts `cpu_reset`.
- Frame error: set `load_error`=1, keep `cpu_reset`=1, return to WAIT_SYNC. Words already written stay in memory.
- Timeout: in GET_COUNT, GET_DATA or GET_CSUM, if TIMEOUT_CLKS cycles pass with no `byte_valid`, it is a frame error. The timeout counter clears on every `byte_valid`.
- Index arithmetic is ADDR_W+1 bits wide, so N=MEM_WORDS does not wrap before the GET_CSUM comparison.

## Timing
- `byte_valid` fires in the cycle after the stop-bit sample. One byte takes about 9.5×CLKS_PER_BIT cycles from the start edge.
- `mem_we` is high for exactly one cycle, in the cycle after the `byte_valid` of the 4th byte. `mem_addr` and `mem_wdata` are valid in that same cycle and hold their values afterwards.
- `cpu_reset` falls, and `load_done` rises, in the cycle after the `byte_valid` of CSUM.
- `cpu_reset` rises in the cycle after the `byte_valid` of an accepted 0xA5.
- `reset` mid-frame: the state returns to reset values in the next cycle. The partial image is abandoned and no further `mem_we` is issued.
- A reset that coincides with `byte_valid` wins, and the byte is dropped.

## Test plan
- Valid load: send A5 01 13 01 C0 0C 1E. Expect `mem_we`=1 once with addr 0 and data 0x0CC00113. CSUM = 13^01^C0^0C = 0xDE, so for this case send DE in place of 1E. Expect `cpu_reset` to fall and `load_done`=1.
- Full image: N=8, words 0..7 = 0x00000000..0x00000007. Expect 8 strobes at addresses 0..7 with no wrap, then a successful release.
- Bad checksum: the valid frame above with CSUM 0x00. Expect `load_error`=1, `cpu_reset`=1, `load_done`=0, and the word at addr 0 still written.
- Bad count: A5 00, then A5 09. Expect `load_error`=1 after each, with no `mem_we`.
- Timeout and framing: stop sending after 2 data bytes. Expect `load_error` after TIMEOUT_CLKS. In a separate run, send a byte with stop bit 0 mid-frame and expect `load_error`.
- Restart and reset: after a successful load, send A5 and expect `cpu_reset`=1 next cycle. Assert `reset` mid-GET_DATA and expect all outputs at reset values with no strobe. A 0.3-bit low glitch on `uart_rx` must produce no byte.
